aes_req_arbiter: RTL and testbench
==================================

AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles WAIT holds for core_done before an error response.
REQ-002 Port clk input 1: single clock; all logic rising-edge.
REQ-003 Port reset_n input 1: reset is synchronous and active-low.
REQ-004 Ports req0_valid / req1_valid input 1: requester N offers a block.
REQ-005 Ports req0_ready / req1_ready output 1: arbiter accepts requester N this cycle.
REQ-006 Ports req0_pt / req1_pt input 128: plaintext from requester N.
REQ-007 Ports req0_key / req1_key input 128: cipher key from requester N.
REQ-008 Port core_start output 1: one-cycle start pulse to the shared AES-128 core.
REQ-009 Ports core_pt / core_key output 128 each: operands to the core.
REQ-010 Port core_done input 1: core finished (one-cycle pulse).
REQ-011 Port core_ct input 128: core ciphertext, valid with core_done.
REQ-012 Ports rsp_valid output 1 / rsp_ready input 1: response handshake.
REQ-013 Ports rsp_id output 1 / rsp_ct output 128 / rsp_err output 1: owner id, ciphertext, timeout flag.
REQ-014 Port busy output 1: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, START, WAIT, RESP; transitions IDLE->START on accept, START->WAIT always, WAIT->RESP on core_done or timeout, RESP->IDLE on rsp_ready.
REQ-016 In IDLE, grant SHALL be round-robin: one valid -> that one; both valid -> requester not equal to last_grant.
REQ-017 reqN_ready SHALL be high only in IDLE and only for the granted requester; never both high.
REQ-018 On accept (valid & ready), pt, key and grant id SHALL be latched; last_grant SHALL update to the accepted id.
REQ-019 core_start SHALL be high exactly during the single START cycle.
REQ-020 core_pt/core_key SHALL come from the latched registers, stable from START through RESP.
REQ-021 WAIT SHALL run an 8-bit cycle counter cleared on entry.
REQ-022 core_done in WAIT SHALL latch core_ct into rsp_ct with rsp_err=0.
REQ-023 If the counter reaches TIMEOUT with no core_done: rsp_ct=0, rsp_err=1.
REQ-024 core_done together with the timeout count in the same cycle SHALL count as success.
REQ-025 core_done outside WAIT SHALL be ignored.
REQ-026 rsp_valid SHALL be high throughout RESP; rsp_id, rsp_ct and rsp_err SHALL hold until rsp_ready.
REQ-027 Latency: accept at edge T, core_start high in cycle T+1, core_done seen in cycle D gives rsp_valid in cycle D+1.
REQ-028 No new request SHALL be accepted before the current response completes; reqN_valid is held by requesters until ready.

Reset
REQ-029 reset_n low at a clock edge SHALL force IDLE, last_grant=1 (req0 wins first tie), counter=0, and all outputs 0 (req*_ready, core_start, core_pt, core_key, rsp_valid, rsp_id, rsp_ct, rsp_err, busy).
REQ-030 A reset mid-operation SHALL abandon the transaction with no response; a later core_done SHALL be ignored.

Structure
REQ-031 Package aes_pkg SHALL hold the state encoding (IDLE=0, START=1, WAIT=2, RESP=3), the TIMEOUT default and the 128-bit block width constant.
REQ-032 Sub-module rr_arbiter2 SHALL hold the 2-way round-robin grant logic and the last_grant register.

Verification
REQ-033 Only req0_valid with pt=00112233445566778899aabbccddeeff and key=000102030405060708090a0b0c0d0e0f, core model done after 54 cycles with ct=69c4e0d86a7b0430d8cdb78070b4c55a -> rsp_id=0, rsp_err=0, rsp_ct matches, core_start pulsed once.
REQ-034 Both valid from reset, three back-to-back transactions -> grants in order 0, 1, 0; req0_ready and req1_ready never high together.
REQ-035 Core never asserts done, TIMEOUT=255 -> rsp_valid in cycle 256 after WAIT entry, rsp_err=1, rsp_ct=0.
REQ-036 rsp_ready held low 10 cycles -> rsp_valid and its data stay stable; no req*_ready during the stall.
REQ-037 reset_n low for one cycle during WAIT, then core_done pulses -> no rsp_valid, all outputs 0, busy=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants for the AES request arbiter: FSM encoding, block width
// and the default WAIT timeout.
package aes_pkg;

   localparam int BLOCK_W     = 128;
   localparam int CNT_W       = 8;
   localparam int TIMEOUT_DEF = 255;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with its last-grant history register.
// A tie goes to the requester that was not served most recently.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable_i,
   input  logic [1:0] req_i,
   output logic [1:0] ready_o,
   output logic       accept_o,
   output logic       gnt_id_o
);

   logic last_q;
   logic last_d;

   assign gnt_id_o = (&req_i) ? ~last_q : req_i[1];
   assign ready_o  = (enable_i && (|req_i)) ? (gnt_id_o ? 2'b10 : 2'b01) : 2'b00;
   // Ready is only raised toward a valid requester, so any ready is an accept.
   assign accept_o = |ready_o;
   assign last_d   = accept_o ? gnt_id_o : last_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES-128 core between two requesters: round-robin accept, start
// pulse, bounded wait for core_done, then a held response until rsp_ready.
module aes_req_arbiter
   import aes_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               req0_valid,
   input  logic               req1_valid,
   output logic               req0_ready,
   output logic               req1_ready,
   input  logic [BLOCK_W-1:0] req0_pt,
   input  logic [BLOCK_W-1:0] req1_pt,
   input  logic [BLOCK_W-1:0] req0_key,
   input  logic [BLOCK_W-1:0] req1_key,
   output logic               core_start,
   output logic [BLOCK_W-1:0] core_pt,
   output logic [BLOCK_W-1:0] core_key,
   input  logic               core_done,
   input  logic [BLOCK_W-1:0] core_ct,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [BLOCK_W-1:0] rsp_ct,
   output logic               rsp_err,
   output logic               busy
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   logic [1:0]         state_q,  state_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [BLOCK_W-1:0] pt_q,     pt_d;
   logic [BLOCK_W-1:0] key_q,    key_d;
   logic               id_q,     id_d;
   logic [BLOCK_W-1:0] rsp_ct_q, rsp_ct_d;
   logic               rsp_err_q, rsp_err_d;

   logic [1:0] arb_ready;
   logic       arb_accept;
   logic       arb_gnt;
   logic       arb_enable;

   // Gating with reset_n keeps ready low while reset is being applied.
   assign arb_enable = (state_q == ST_IDLE) && reset_n;

   rr_arbiter2 u_rr (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable_i (arb_enable),
      .req_i    ({req1_valid, req0_valid}),
      .ready_o  (arb_ready),
      .accept_o (arb_accept),
      .gnt_id_o (arb_gnt)
   );

   // NOTE: every next-state signal gets a default first so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pt_d      = pt_q;
      key_d     = key_q;
      id_d      = id_q;
      rsp_ct_d  = rsp_ct_q;
      rsp_err_d = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_accept) begin
               pt_d    = arb_gnt ? req1_pt  : req0_pt;
               key_d   = arb_gnt ? req1_key : req0_key;
               id_d    = arb_gnt;
               state_d = ST_START;
            end
         end
         ST_START: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A done arriving on the timeout cycle still counts as success.
            if (core_done) begin
               rsp_ct_d  = core_ct;
               rsp_err_d = 1'b0;
               state_d   = ST_RESP;
            end else if (cnt_q == TIMEOUT_CNT) begin
               rsp_ct_d  = '0;
               rsp_err_d = 1'b1;
               state_d   = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: the wide data registers are reset too, because every output they
   // drive must read zero after reset, not merely be ignored.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pt_q      <= '0;
         key_q     <= '0;
         id_q      <= 1'b0;
         rsp_ct_q  <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pt_q      <= pt_d;
         key_q     <= key_d;
         id_q      <= id_d;
         rsp_ct_q  <= rsp_ct_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign req0_ready = arb_ready[0];
   assign req1_ready = arb_ready[1];
   assign core_start = (state_q == ST_START);
   assign core_pt    = pt_q;
   assign core_key   = key_q;
   assign rsp_valid  = (state_q == ST_RESP);
   assign rsp_id     = id_q;
   assign rsp_ct     = rsp_ct_q;
   assign rsp_err    = rsp_err_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Randomized self-checking bench for aes_req_arbiter with a transaction-level
// model of the requesters, grant history and core timing.
module tb_aes_req_arbiter;

   localparam int TO = 255;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [127:0] req0_pt, req1_pt, req0_key, req1_key;
   logic         core_start;
   logic [127:0] core_pt, core_key;
   logic         core_done;
   logic [127:0] core_ct;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
   logic [127:0] rsp_ct;

   aes_req_arbiter #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .req0_pt    (req0_pt),
      .req1_pt    (req1_pt),
      .req0_key   (req0_key),
      .req1_key   (req1_key),
      .core_start (core_start),
      .core_pt    (core_pt),
      .core_key   (core_key),
      .core_done  (core_done),
      .core_ct    (core_ct),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_ct     (rsp_ct),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int both_rdy = 0;
   int exp_starts = 0;

   // Requester model: pending flag and offered block per requester.
   bit           pend [2];
   logic [127:0] mpt  [2];
   logic [127:0] mkey [2];
   int           last_g;

   always @(posedge clk) begin
      if (core_start) start_cnt <= start_cnt + 1;
      if (req0_ready && req1_ready) both_rdy <= both_rdy + 1;
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic drive_reqs;
      req0_valid = pend[0];
      req1_valid = pend[1];
      req0_pt    = mpt[0];
      req0_key   = mkey[0];
      req1_pt    = mpt[1];
      req1_key   = mkey[1];
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rdy0"},  req0_ready, 0);
      chk({tag, "_rdy1"},  req1_ready, 0);
      chk({tag, "_start"}, core_start, 0);
      chk({tag, "_cpt"},   core_pt, 0);
      chk({tag, "_ckey"},  core_key, 0);
      chk({tag, "_rv"},    rsp_valid, 0);
      chk({tag, "_rid"},   rsp_id, 0);
      chk({tag, "_rct"},   rsp_ct, 0);
      chk({tag, "_rerr"},  rsp_err, 0);
      chk({tag, "_busy"},  busy, 0);
   endtask

   task automatic do_reset;
      reset_n    = 1'b0;
      pend[0]    = 1'b0;
      pend[1]    = 1'b0;
      drive_reqs();
      rsp_ready  = 1'b0;
      core_done  = 1'b0;
      core_ct    = '0;
      tick();
      tick();
      #1;
      chk_all_zero("reset");
      reset_n = 1'b1;
      last_g  = 1;
   endtask

   // done_dly: WAIT-cycle index of the core_done pulse, -1 for never.
   task automatic run_txn(input int done_dly, input logic [127:0] ct_in,
                          input int stall, output int got_g);
      int g;
      logic [127:0] exp_ct;
      logic exp_err;
      drive_reqs();
      #1;
      g = (pend[0] && pend[1]) ? (1 - last_g) : (pend[1] ? 1 : 0);
      got_g = req1_ready ? 1 : 0;
      chk("grant_rdy0", req0_ready, g == 0);
      chk("grant_rdy1", req1_ready, g == 1);
      chk("idle_busy", busy, 0);
      tick();
      pend[g] = 1'b0;
      last_g  = g;
      exp_starts++;
      drive_reqs();
      #1;
      chk("start_pulse", core_start, 1);
      chk("start_pt", core_pt, mpt[g]);
      chk("start_key", core_key, mkey[g]);
      chk("start_busy", busy, 1);
      chk("start_rdy", {req1_ready, req0_ready}, 0);
      tick();
      exp_ct  = '0;
      exp_err = 1'b1;
      for (int k = 0; k <= TO; k++) begin
         if (k == done_dly) begin
            core_done = 1'b1;
            core_ct   = ct_in;
            exp_ct    = ct_in;
            exp_err   = 1'b0;
         end
         #1;
         chk("wait_rv", rsp_valid, 0);
         chk("wait_start", core_start, 0);
         tick();
         core_done = 1'b0;
         core_ct   = rnd128();
         if (k == done_dly) break;
      end
      for (int s = 0; s <= stall; s++) begin
         rsp_ready = (s == stall);
         #1;
         chk("rsp_valid", rsp_valid, 1);
         chk("rsp_id", rsp_id, g);
         chk("rsp_ct", rsp_ct, exp_ct);
         chk("rsp_err", rsp_err, exp_err);
         chk("rsp_core_pt", core_pt, mpt[g]);
         chk("rsp_rdy", {req1_ready, req0_ready}, 0);
         tick();
      end
      rsp_ready = 1'b0;
      #1;
      chk("done_rv", rsp_valid, 0);
      chk("done_busy", busy, 0);
   endtask

   task automatic load(input int n);
      pend[n] = 1'b1;
      mpt[n]  = rnd128();
      mkey[n] = rnd128();
   endtask

   int g;
   int order [3];

   initial begin
      mpt[0] = '0; mpt[1] = '0; mkey[0] = '0; mkey[1] = '0;
      do_reset();

      // Single known-answer block from requester 0.
      pend[0] = 1'b1;
      mpt[0]  = 128'h00112233445566778899aabbccddeeff;
      mkey[0] = 128'h000102030405060708090a0b0c0d0e0f;
      run_txn(54, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, g);
      chk("kat_id", g, 0);

      // Both requesters contend from reset: grants must alternate 0, 1, 0.
      do_reset();
      load(0);
      load(1);
      for (int i = 0; i < 3; i++) begin
         run_txn($urandom_range(0, 12), rnd128(), 0, g);
         order[i] = g;
         load(g);
      end
      chk("rr_order0", order[0], 0);
      chk("rr_order1", order[1], 1);
      chk("rr_order2", order[2], 0);

      // Response back-pressure, timeout, and done exactly on the timeout cycle.
      run_txn(5, rnd128(), 10, g);
      load(g);
      run_txn(-1, rnd128(), 1, g);
      load(g);
      run_txn(TO, rnd128(), 0, g);

      // Reset in the middle of WAIT, then a stale core_done.
      do_reset();
      pend[0] = 1'b1;
      mpt[0]  = rnd128();
      mkey[0] = rnd128();
      drive_reqs();
      tick();
      pend[0] = 1'b0;
      exp_starts++;
      drive_reqs();
      tick();
      tick();
      tick();
      #1;
      chk("midwait_busy", busy, 1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      last_g  = 1;
      #1;
      chk_all_zero("midrst");
      core_done = 1'b1;
      core_ct   = rnd128();
      tick();
      core_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stale_rv", rsp_valid, 0);
         chk("stale_busy", busy, 0);
         tick();
      end

      // Random traffic against the model.
      for (int t = 0; t < 30; t++) begin
         int r;
         int dly;
         if (!pend[0] && ($urandom_range(0, 1) == 1)) load(0);
         if (!pend[1] && ($urandom_range(0, 1) == 1)) load(1);
         if (!pend[0] && !pend[1]) load($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         dly = (r == 0) ? -1 : ((r == 1) ? TO : $urandom_range(0, 20));
         run_txn(dly, rnd128(), $urandom_range(0, 3), g);
      end

      pend[0] = 1'b0;
      pend[1] = 1'b0;
      drive_reqs();
      tick();
      #1;
      chk("start_pulses", start_cnt, exp_starts);
      chk("never_both_ready", both_rdy, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
